rx_8b10b_sync_ctrl: RTL and testbench
=====================================

// Module: rx_8b10b_sync_ctrl
// PURPOSE
//  Word-alignment and link-sync controller for the serial 8b/10b receive path.
//  Watches each decoded word (K flag + byte, code/disparity errors) from the rx deserializer/decoder.
//  Emits single-cycle bit-slip requests until commas decode cleanly, then declares sync_o.
//  Tracks error density while locked and drops sync when the link degrades.
// PARAMETERS
//  SLIP_WORDS    20  words in HUNT without a clean comma before a slip is issued
//  SETTLE_WORDS  2   word strobes ignored after a slip (decoder pipeline flush)
//  LOCK_COMMAS   4   consecutive clean commas needed to enter LOCKED
//  MAX_GAP       16  max words between commas while in CONFIRM
//  LOSS_ERRS     4   error-budget level that drops sync
//  RECOVER_WORDS 4   consecutive clean words that refund one error-budget unit
//  CNT_W         16  width of err_total_o
// PORTS
//  clk_i         in   1      clock
//  rst_i         in   1      asynchronous reset, active-high
//  word_valid_i  in   1      1-clk strobe: data_i/code_err_i/disp_err_i valid this cycle
//  data_i        in   9      decoded word, [8]=K flag, [7:0]=byte
//  code_err_i    in   1      decoder code-violation flag for this word
//  disp_err_i    in   1      decoder running-disparity error flag for this word
//  err_clr_i     in   1      synchronous clear of err_total_o
//  slip_o        out  1      1-clk pulse: rx bit counter holds one clk (shifts boundary 1 bit)
//  sync_o        out  1      link aligned (state == LOCKED)
//  state_o       out  2      current FSM state (encoding from package)
//  err_total_o   out  CNT_W  saturating count of bad words seen while LOCKED
// BEHAVIOUR
//  Reset: state HUNT, slip_o=0, sync_o=0, state_o=HUNT, err_total_o=0, all internal counters 0.
//  Comma word = K28.1/K28.5/K28.7 (9'h13C/9'h1BC/9'h1FC). Clean word = !code_err_i && !disp_err_i.
//  Bad word = code_err_i || disp_err_i.
//  Integration: rx eob is delayed so word_valid_i is coincident with its data/error flags.
//  Inputs are evaluated only on word_valid_i cycles. All outputs are registered.
//  Each output responds 1 clk after the deciding strobe.
//  HUNT:
//   - Clean comma -> CONFIRM, with comma_cnt=1 and gap=0.
//   - Any other word -> miss_cnt++.
//   - miss_cnt reaching SLIP_WORDS -> slip_o pulse, go to SLIP_WAIT, miss_cnt=0.
//  SLIP_WAIT:
//   - Count SETTLE_WORDS strobes, contents ignored, then go to HUNT.
//   - slip_o is never reasserted before the settle period ends.
//  CONFIRM:
//   - Bad word, or gap exceeding MAX_GAP -> slip_o pulse and go to SLIP_WAIT.
//   - Clean comma -> comma_cnt++ and gap=0. Clean non-comma -> gap++.
//   - comma_cnt reaching LOCK_COMMAS -> LOCKED. sync_o=1 the clk after that strobe.
//  LOCKED:
//   - Bad word -> budget++, good_run=0, err_total_o++ (saturates at all-ones).
//   - Clean word -> good_run++. At RECOVER_WORDS: budget-- (floor 0), good_run=0.
//   - budget reaching LOSS_ERRS -> HUNT, sync_o=0. No slip issued; miss_cnt starts at 0.
//  Simultaneous events:
//   - err_clr_i together with a counted bad word -> err_total_o=0 (clear wins).
//   - Bad word while good_run hits its limit -> bad word wins (no refund).
//  Reset asserted mid-operation returns immediately to reset values.
//   - A slip_o pulse in flight is cut off.
//  word_valid_i low: the FSM and all counters hold.
// STRUCTURE
//  Package rx_sync_pkg:
//   - state enum {HUNT, SLIP_WAIT, CONFIRM, LOCKED}, 2-bit.
//   - K28_1/K28_5/K28_7 9-bit constants.
//   - is_comma() function.
//  Sub-module rx_sync_err_mon:
//   - LOCKED error budget, good-run refund counter and saturating err_total.
//   - Enabled only in LOCKED; cleared on LOCKED entry.
//  Top level holds the FSM, miss/gap/comma/settle counters and the slip pulse register.
// TESTING
//  1. Clean K28.5 every 8th word, otherwise D words:
//     sync_o=1 one clk after the 4th comma strobe; slip_o never pulses; state_o walks HUNT->CONFIRM->LOCKED.
//  2. 20 strobes with no comma:
//     slip_o high exactly 1 clk after the 20th strobe.
//     The next 2 strobes are ignored, then state_o=HUNT.
//  3. LOCKED, 4 code_err words 1 word apart:
//     sync_o=0 one clk after the 4th bad strobe; err_total_o=4; no slip_o.
//  4. LOCKED, bad words separated by 4 clean words:
//     sync_o stays 1; err_total_o counts every bad word.
//  5. CONFIRM with comma_cnt=2, then 17 clean non-comma words:
//     slip_o pulse after the 17th; state SLIP_WAIT.
//  6. err_clr_i with a bad LOCKED word -> err_total_o=0.
//     rst_i mid-LOCKED -> sync_o=0, state_o=HUNT, err_total_o=0 asynchronously.

Source files
------------

// File: rtl/rx_sync_pkg.sv
// Shared state encoding and comma definitions for the 8b/10b receive sync controller.
package rx_sync_pkg;

    localparam logic [1:0] StHunt     = 2'd0;
    localparam logic [1:0] StSlipWait = 2'd1;
    localparam logic [1:0] StConfirm  = 2'd2;
    localparam logic [1:0] StLocked   = 2'd3;

    localparam logic [8:0] K28_1 = 9'h13C;
    localparam logic [8:0] K28_5 = 9'h1BC;
    localparam logic [8:0] K28_7 = 9'h1FC;

    function automatic logic is_comma(input logic [8:0] word);
        return (word == K28_1) || (word == K28_5) || (word == K28_7);
    endfunction

endpackage

// File: rtl/rx_sync_err_mon.sv
// Error-budget tracker used while the link is locked; raises loss_o on the strobe that
// exhausts the budget and keeps a saturating total of bad words.
module rx_sync_err_mon #(
    parameter int unsigned LOSS_ERRS     = 4,
    parameter int unsigned RECOVER_WORDS = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             strobe_i,
    input  logic             bad_i,
    input  logic             err_clr_i,
    output logic             loss_o,
    output logic [CNT_W-1:0] err_total_o
);

    localparam int unsigned BudgetW = $clog2(LOSS_ERRS + 1);
    localparam int unsigned RunW    = $clog2(RECOVER_WORDS + 1);
    localparam logic [BudgetW-1:0] BudgetLast = BudgetW'(LOSS_ERRS - 1);
    localparam logic [RunW-1:0]    RunLast    = RunW'(RECOVER_WORDS - 1);

    logic [BudgetW-1:0] budget_q, budget_d;
    logic [RunW-1:0]    run_q, run_d;
    logic [CNT_W-1:0]   total_q, total_d;

    always_comb begin
        budget_d = budget_q;
        run_d    = run_q;
        total_d  = total_q;
        loss_o   = 1'b0;
        // Outside LOCKED the budget is parked at zero, so every lock starts fresh.
        if (!en_i) begin
            budget_d = '0;
            run_d    = '0;
        end else if (strobe_i) begin
            if (bad_i) begin
                budget_d = budget_q + BudgetW'(1);
                run_d    = '0;
                loss_o   = (budget_q == BudgetLast);
                if (total_q != '1) begin
                    total_d = total_q + CNT_W'(1);
                end
            end else if (run_q == RunLast) begin
                run_d = '0;
                if (budget_q != '0) begin
                    budget_d = budget_q - BudgetW'(1);
                end
            end else begin
                run_d = run_q + RunW'(1);
            end
        end
        if (err_clr_i) begin
            total_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            budget_q <= '0;
            run_q    <= '0;
            total_q  <= '0;
        end else begin
            budget_q <= budget_d;
            run_q    <= run_d;
            total_q  <= total_d;
        end
    end

    assign err_total_o = total_q;

endmodule

// File: rtl/rx_8b10b_sync_ctrl.sv
// Word-alignment FSM for the 8b/10b receive path: slips the bit boundary until commas
// decode cleanly, declares sync, and hands error tracking to rx_sync_err_mon once locked.
module rx_8b10b_sync_ctrl
    import rx_sync_pkg::*;
#(
    parameter int unsigned SLIP_WORDS    = 20,
    parameter int unsigned SETTLE_WORDS  = 2,
    parameter int unsigned LOCK_COMMAS   = 4,
    parameter int unsigned MAX_GAP       = 16,
    parameter int unsigned LOSS_ERRS     = 4,
    parameter int unsigned RECOVER_WORDS = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             word_valid_i,
    input  logic [8:0]       data_i,
    input  logic             code_err_i,
    input  logic             disp_err_i,
    input  logic             err_clr_i,
    output logic             slip_o,
    output logic             sync_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] err_total_o
);

    localparam int unsigned MissW   = $clog2(SLIP_WORDS + 1);
    localparam int unsigned GapW    = $clog2(MAX_GAP + 2);
    localparam int unsigned CommaW  = $clog2(LOCK_COMMAS + 1);
    localparam int unsigned SettleW = $clog2(SETTLE_WORDS + 1);
    localparam logic [MissW-1:0]   MissLast   = MissW'(SLIP_WORDS - 1);
    localparam logic [GapW-1:0]    GapMax     = GapW'(MAX_GAP);
    localparam logic [CommaW-1:0]  CommaLast  = CommaW'(LOCK_COMMAS - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_WORDS - 1);

    logic [1:0]         state_q, state_d;
    logic [MissW-1:0]   miss_q, miss_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [CommaW-1:0]  comma_q, comma_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic               slip_q, slip_d;
    logic               clean, comma, loss;

    assign clean = !code_err_i && !disp_err_i;
    assign comma = is_comma(data_i);

    rx_sync_err_mon #(
        .LOSS_ERRS    (LOSS_ERRS),
        .RECOVER_WORDS(RECOVER_WORDS),
        .CNT_W        (CNT_W)
    ) u_err_mon (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (state_q == StLocked),
        .strobe_i   (word_valid_i),
        .bad_i      (!clean),
        .err_clr_i  (err_clr_i),
        .loss_o     (loss),
        .err_total_o(err_total_o)
    );

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        gap_d    = gap_q;
        comma_d  = comma_q;
        settle_d = settle_q;
        slip_d   = 1'b0;
        if (word_valid_i) begin
            unique case (state_q)
                StHunt: begin
                    if (clean && comma) begin
                        state_d = StConfirm;
                        comma_d = CommaW'(1);
                        gap_d   = '0;
                        miss_d  = '0;
                    end else if (miss_q == MissLast) begin
                        slip_d   = 1'b1;
                        state_d  = StSlipWait;
                        miss_d   = '0;
                        settle_d = '0;
                    end else begin
                        miss_d = miss_q + MissW'(1);
                    end
                end
                StSlipWait: begin
                    if (settle_q == SettleLast) begin
                        state_d  = StHunt;
                        settle_d = '0;
                        miss_d   = '0;
                    end else begin
                        settle_d = settle_q + SettleW'(1);
                    end
                end
                StConfirm: begin
                    if (!clean || (!comma && gap_q == GapMax)) begin
                        slip_d   = 1'b1;
                        state_d  = StSlipWait;
                        settle_d = '0;
                        comma_d  = '0;
                        gap_d    = '0;
                    end else if (comma) begin
                        gap_d = '0;
                        if (comma_q == CommaLast) begin
                            state_d = StLocked;
                            comma_d = '0;
                        end else begin
                            comma_d = comma_q + CommaW'(1);
                        end
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
                StLocked: begin
                    // Loss of sync goes straight back to HUNT without a slip.
                    if (loss) begin
                        state_d = StHunt;
                        miss_d  = '0;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StHunt;
            miss_q   <= '0;
            gap_q    <= '0;
            comma_q  <= '0;
            settle_q <= '0;
            slip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            gap_q    <= gap_d;
            comma_q  <= comma_d;
            settle_q <= settle_d;
            slip_q   <= slip_d;
        end
    end

    assign slip_o  = slip_q;
    assign sync_o  = (state_q == StLocked);
    assign state_o = state_q;

endmodule

// File: tb/tb_rx_8b10b_sync_ctrl.sv
// Directed and randomized bench for rx_8b10b_sync_ctrl against a per-word behavioural model.
module tb_rx_8b10b_sync_ctrl;
    import rx_sync_pkg::*;

    localparam int SlipWords = 20;
    localparam int SettleWords = 2;
    localparam int LockCommas = 4;
    localparam int MaxGap = 16;
    localparam int LossErrs = 4;
    localparam int RecoverWords = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        word_valid = 1'b0;
    logic [8:0]  data = '0;
    logic        code_err = 1'b0;
    logic        disp_err = 1'b0;
    logic        err_clr = 1'b0;
    logic        slip, sync;
    logic [1:0]  state;
    logic [15:0] err_total;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [1:0] m_state;
    int         m_miss, m_gap, m_commas, m_settle, m_budget, m_run, m_total;
    logic       m_slip;

    always #5 clk = ~clk;

    rx_8b10b_sync_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .word_valid_i(word_valid),
        .data_i      (data),
        .code_err_i  (code_err),
        .disp_err_i  (disp_err),
        .err_clr_i   (err_clr),
        .slip_o      (slip),
        .sync_o      (sync),
        .state_o     (state),
        .err_total_o (err_total)
    );

    task automatic model_reset();
        m_state = StHunt;
        m_miss = 0; m_gap = 0; m_commas = 0; m_settle = 0;
        m_budget = 0; m_run = 0; m_total = 0; m_slip = 1'b0;
    endtask

    task automatic model_slip();
        m_slip = 1'b1;
        m_state = StSlipWait;
        m_settle = 0;
        m_miss = 0;
    endtask

    task automatic model_word(input logic [8:0] d, input bit bad, input bit clr);
        bit cm;
        cm = (d == 9'h13C) || (d == 9'h1BC) || (d == 9'h1FC);
        m_slip = 1'b0;
        case (m_state)
            StHunt: begin
                if (!bad && cm) begin
                    m_state = StConfirm; m_commas = 1; m_gap = 0; m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == SlipWords) model_slip();
                end
            end
            StSlipWait: begin
                m_settle++;
                if (m_settle == SettleWords) begin
                    m_state = StHunt; m_settle = 0;
                end
            end
            StConfirm: begin
                if (bad) model_slip();
                else if (cm) begin
                    m_commas++; m_gap = 0;
                    if (m_commas == LockCommas) begin
                        m_state = StLocked; m_budget = 0; m_run = 0;
                    end
                end else begin
                    m_gap++;
                    if (m_gap > MaxGap) model_slip();
                end
            end
            default: begin
                if (bad) begin
                    m_budget++; m_run = 0;
                    if (m_total < 65535) m_total++;
                    if (m_budget == LossErrs) begin
                        m_state = StHunt; m_miss = 0;
                    end
                end else begin
                    m_run++;
                    if (m_run == RecoverWords) begin
                        m_run = 0;
                        if (m_budget > 0) m_budget--;
                    end
                end
            end
        endcase
        if (clr) m_total = 0;
    endtask

    task automatic check(input string tag);
        logic exp_sync;
        exp_sync = (m_state == StLocked);
        n_checks++;
        assert (slip === m_slip) else begin
            n_fail++;
            $error("FAIL %s slip_o: observed %0b expected %0b", tag, slip, m_slip);
        end
        n_checks++;
        assert (sync === exp_sync) else begin
            n_fail++;
            $error("FAIL %s sync_o: observed %0b expected %0b", tag, sync, exp_sync);
        end
        n_checks++;
        assert (state === m_state) else begin
            n_fail++;
            $error("FAIL %s state_o: observed %0d expected %0d", tag, state, m_state);
        end
        n_checks++;
        assert (err_total === 16'(m_total)) else begin
            n_fail++;
            $error("FAIL %s err_total_o: observed %0d expected %0d", tag, err_total, m_total);
        end
    endtask

    task automatic send(input logic [8:0] d, input logic ce, input logic de, input logic clr,
                        input string tag);
        @(negedge clk);
        word_valid = 1'b1; data = d; code_err = ce; disp_err = de; err_clr = clr;
        @(posedge clk);
        #1;
        word_valid = 1'b0; code_err = 1'b0; disp_err = 1'b0; err_clr = 1'b0;
        data = 9'($urandom);
        model_word(d, ce || de, clr);
        check(tag);
    endtask

    // Idle cycles between strobes: everything must hold and slip_o must be low.
    task automatic idle_gap(input string tag);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            m_slip = 1'b0;
            check(tag);
        end
    endtask

    function automatic logic [8:0] dword();
        return {1'b0, 8'($urandom)};
    endfunction

    task automatic send_bad(input string tag);
        logic [1:0] r;
        r = 2'($urandom_range(1, 3));
        send(dword(), r[0], r[1], 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset("reset");

        // Clean K28.5 every 8th word locks after the 4th comma.
        for (int i = 0; i < 40; i++) begin
            send((i % 8 == 0) ? K28_5 : dword(), 1'b0, 1'b0, 1'b0, "lock_k28_5");
            idle_gap("lock_idle");
        end

        // Bad words spaced by RECOVER_WORDS clean words keep sync.
        for (int i = 0; i < 3; i++) begin
            send_bad("spaced_bad");
            for (int j = 0; j < RecoverWords; j++) send(dword(), 1'b0, 1'b0, 1'b0, "spaced_good");
        end
        send(dword(), 1'b0, 1'b0, 1'b1, "clr_good");
        send_bad("clr_setup");
        @(negedge clk);
        word_valid = 1'b1; data = dword(); code_err = 1'b1; err_clr = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0; code_err = 1'b0; err_clr = 1'b0;
        model_word(data, 1'b1, 1'b1);
        check("clr_with_bad");
        for (int i = 0; i < 12; i++) send(dword(), 1'b0, 1'b0, 1'b0, "drain");

        // Four bad words one word apart drop sync without a slip.
        for (int i = 0; i < 4; i++) begin
            send_bad("loss_bad");
            if (i < 3) send(dword(), 1'b0, 1'b0, 1'b0, "loss_good");
        end

        // 20 strobes without a comma: slip, then two ignored strobes.
        for (int i = 0; i < SlipWords + SettleWords; i++) begin
            send(dword(), 1'b0, 1'b0, 1'b0, "hunt_slip");
            idle_gap("hunt_idle");
        end

        // CONFIRM with two commas, then 17 clean non-commas exceeds the gap.
        send(K28_1, 1'b0, 1'b0, 1'b0, "gap_c1");
        send(K28_7, 1'b0, 1'b0, 1'b0, "gap_c2");
        for (int i = 0; i < MaxGap + 1; i++) send(dword(), 1'b0, 1'b0, 1'b0, "gap_word");
        for (int i = 0; i < SettleWords; i++) send(K28_5, 1'b0, 1'b0, 1'b0, "gap_settle");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) send(K28_5, 1'b0, 1'b0, 1'b0, "rand_comma");
            else if (r < 30) send_bad("rand_bad");
            else if (r < 33) send(K28_5, 1'b1, 1'b0, 1'b0, "rand_bad_comma");
            else send(dword(), 1'b0, 1'b0, 1'b0, "rand_data");
            idle_gap("rand_idle");
        end

        // Relock with commas, bounded, then reset mid-LOCKED.
        for (int i = 0; i < 16 && m_state != StLocked; i++) begin
            send((i % 2 == 0) ? K28_1 : K28_7, 1'b0, 1'b0, 1'b0, "relock");
        end
        n_checks++;
        assert (m_state == StLocked && sync === 1'b1) else begin
            n_fail++;
            $error("FAIL relock_bound: sync_o observed %0b expected 1", sync);
        end
        send_bad("pre_rst_bad");
        send_bad("pre_rst_bad");
        do_reset("rst_locked");

        // Reset cuts off a slip pulse in flight.
        for (int i = 0; i < SlipWords; i++) send(dword(), 1'b0, 1'b0, 1'b0, "slip_cut");
        do_reset("rst_slip");
        send(K28_5, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
